// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: WIDTH-cycle shift-add multiply or restoring
// divide on operand magnitudes, then a single SIGN cycle applies sign fixups.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oprnd1,
  input  logic [WIDTH-1:0] oprnd2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_raw, b_mag, acc, q;
  logic             neg_a, neg_b;

  // op[0] selects signed, op[1] selects divide
  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH:0]   msum, shl, dif;
  logic             ge;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    a_neg_in = op[0] & oprnd1[WIDTH-1];
    b_neg_in = op[0] & oprnd2[WIDTH-1];
    a_mag_in = a_neg_in ? -oprnd1 : oprnd1;
    b_mag_in = b_neg_in ? -oprnd2 : oprnd2;
    msum     = {1'b0, acc} + (q[0] ? {1'b0, b_mag} : '0);
    shl      = {acc, q[WIDTH-1]};
    dif      = shl - {1'b0, b_mag};
    ge       = ~dif[WIDTH];
    prod_neg = -{acc, q};
  end

  // acc/q hold {upper,lower} product when multiplying, {remainder,quotient} when dividing
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      op_r  <= '0;
      a_raw <= '0;
      b_mag <= '0;
      acc   <= '0;
      q     <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            op_r  <= op;
            a_raw <= oprnd1;
            b_mag <= b_mag_in;
            acc   <= '0;
            q     <= a_mag_in;
            neg_a <= a_neg_in;
            neg_b <= b_neg_in;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (op_r[1]) begin
              acc <= ge ? dif[WIDTH-1:0] : shl[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], ge};
            end else begin
              acc <= msum[WIDTH:1];
              q   <= {msum[0], q[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= SIGN;
          end
        end
        SIGN: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            dbz  <= 1'b0;
            case (op_r)
              2'b01: begin
                if (neg_a ^ neg_b) {hi, lo} <= prod_neg;
                else               {hi, lo} <= {acc, q};
              end
              2'b11: begin
                lo <= (neg_a ^ neg_b) ? -q : q;
                hi <= neg_a ? -acc : acc;
              end
              default: begin
                hi <= acc;
                lo <= q;
              end
            endcase
            // divide by zero overrides whatever the datapath produced
            if (op_r[1] && b_mag == '0) begin
              lo  <= '1;
              hi  <= a_raw;
              dbz <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes reference results, a
// negedge monitor pops on done and tracks expected busy/hi/lo/dbz every cycle.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         CLK, RST, start, flush;
  logic [1:0]   op;
  logic [W-1:0] oprnd1, oprnd2;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .oprnd1(oprnd1),
    .oprnd2(oprnd2), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dbz(dbz)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0, n_fail = 0, cyc = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_dbz = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb_, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.dbz = 1'b0;
    e.due = 0;
    case (o)
      2'd0: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = 64'(sa * sb_); e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dbz = 1'b1;
        end else if (o == 2'd2) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          sq = sa / sb_; sr = sa % sb_;
          e.lo = 32'(sq); e.hi = 32'(sr);
        end
      end
    endcase
    return e;
  endfunction

  // monitor
  always @(negedge CLK) begin
    if (sb.size() != 0 && cyc > sb[0].due) begin
      chk("missed_done", 64'(cyc), 64'(sb[0].due));
      void'(sb.pop_front());
    end
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", 64'(cyc), 64'(e.due));
        m_hi = e.hi; m_lo = e.lo; m_dbz = e.dbz;
      end
      chk("busy_in_done", 64'(busy), 64'd0);
    end
    chk("busy", 64'(busy), 64'(sb.size() != 0));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("dbz", 64'(dbz), 64'(m_dbz));
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge CLK);
    while (busy && t < 200) begin @(negedge CLK); t++; end
    if (t >= 200) chk("idle_timeout", 64'(t), 64'd0);
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge CLK);
    while (!done && t < 200) begin @(negedge CLK); t++; end
    if (t >= 200) chk("done_timeout", 64'(t), 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; oprnd1 = a; oprnd2 = b;
    @(posedge CLK); #1;
    e = model(o, a, b);
    e.due = cyc + W + 1;
    sb.push_back(e);
    start = 1'b0; op = 2'($urandom); oprnd1 = $urandom; oprnd2 = $urandom;
    if (noise) begin
      repeat (5) begin
        @(negedge CLK);
        start = 1'($urandom); op = 2'($urandom); oprnd1 = $urandom; oprnd2 = $urandom;
      end
      start = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RST = 1'b1; start = 1'b0; flush = 1'b0; op = '0; oprnd1 = '0; oprnd2 = '0;
    #22;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    RST = 1'b0;

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'd1, -32'sd3, 32'd7, 1'b0);
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(2'd3, -32'sd7, 32'd2, 1'b0);
    issue(2'd2, 32'd100, 32'd7, 1'b0);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'd2, 32'd5, 32'd0, 1'b0);
    issue(2'd0, 32'd2, 32'd3, 1'b0);

    // flush mid-run: result dropped, outputs keep previous values
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (10) @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    sb.delete();
    issue(2'd1, 32'hFFFF_FFF0, 32'd9, 1'b0);

    // flush beats start in IDLE
    wait_done();
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; op = 2'd0; oprnd1 = 32'd3; oprnd2 = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0; flush = 1'b0;

    // flush during done cycle leaves the written result
    issue(2'd3, 32'd1000, -32'sd33, 1'b0);
    wait_done();
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;

    // async reset mid-run with noisy inputs while busy
    issue(2'd1, 32'd77, -32'sd5, 1'b1);
    repeat (8) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    sb.delete();
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_dbz", 64'(dbz), 64'd0);
    @(negedge CLK);
    #2 RST = 1'b0;
    issue(2'd1, 32'd77, -32'sd5, 1'b1);

    for (int i = 0; i < 150; i++)
      issue(2'($urandom), pick(), pick(), 1'($urandom));

    wait_idle();
    repeat (3) @(negedge CLK);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
